// File: rtl/ipl_pkg.sv
// ipl_pkg: shared types and constants for the 68000 interrupt priority
// encoder (ipl_encoder and its stability filter).
//   state_e        acknowledge-cycle FSM states
//   IPL_NONE       _IPL pattern meaning "no request"
//   LVL_NMI        non-maskable level (edge-triggered on the 68000)
//   ACK_ADDR_MASK  address bits [23:4] that must all be ones in an
//                  interrupt-acknowledge cycle; bits [3:1] carry the level
//   sat6()         clamps a Paula level into 0..6
package ipl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    WAIT_AS = 2'd2
  } state_e;

  localparam logic [2:0]  IPL_NONE      = 3'b111;
  localparam logic [2:0]  LVL_NMI       = 3'd7;
  localparam logic [22:0] ACK_ADDR_MASK = 23'h7FFFF8;

  // Paula can never legitimately request level 7, so a 7 is taken as 6.
  function automatic logic [2:0] sat6(input logic [2:0] lvl);
    if (lvl == 3'd7) begin
      sat6 = 3'd6;
    end else begin
      sat6 = lvl;
    end
  endfunction

endpackage

// File: rtl/ipl_filter.sv
// ipl_filter: holds back a change of the requested level until it has been
// stable for FILTER cycles, then presents it on the active-low _ipl lines.
//   clk_i     system clock
//   reset_i   synchronous, active-high reset
//   freeze_i  holds counter, candidate and _ipl (acknowledge in progress)
//   req_i     requested level 0..7
//   cand_o    level currently presented to the CPU
//   _ipl_o    ~cand_o, registered
module ipl_filter
  import ipl_pkg::*;
#(
  parameter int FILTER = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       freeze_i,
  input  logic [2:0] req_i,
  output logic [2:0] cand_o,
  output logic [2:0] _ipl_o
);

  localparam logic [2:0] FILT_LAST = 3'(FILTER - 1);

  logic [2:0] cnt_q,  cnt_d;
  logic [2:0] prev_q, prev_d;
  logic [2:0] cand_q, cand_d;
  logic [2:0] ipl_q,  ipl_d;

  // Stability counter: any change of req restarts it; the FILTER-th stable
  // cycle commits req as the new candidate and drives it onto _ipl.
  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    cand_d = cand_q;
    ipl_d  = ipl_q;
    if (freeze_i) begin
      cnt_d  = cnt_q;
    end else begin
      prev_d = req_i;
      if (req_i != prev_q) begin
        cnt_d = 3'd0;
      end else if (req_i != cand_q) begin
        if (cnt_q == FILT_LAST) begin
          cand_d = req_i;
          ipl_d  = ~req_i;
          cnt_d  = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else begin
        cnt_d = 3'd0;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= 3'd0;
      prev_q <= 3'd0;
      cand_q <= 3'd0;
      ipl_q  <= IPL_NONE;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      cand_q <= cand_d;
      ipl_q  <= ipl_d;
    end
  end

  assign cand_o = cand_q;
  assign _ipl_o = ipl_q;

endmodule

// File: rtl/ipl_encoder.sv
// ipl_encoder: encodes Paula's interrupt level and the cartridge level-7
// request onto the 68000 _IPL[2:0] lines, detects the autovector
// acknowledge cycle and re-arms level 7 after it is taken.
//   clk_i, reset_i   clock, synchronous active-high reset
//   irq_level_i      Paula level (0 = none, 7 treated as 6)
//   int7_i           cartridge level-7 request, rising edge used
//   cpu_address_i    CPU address [23:1]
//   _cpu_as_i        address strobe, active low
//   cpu_rd_i         read cycle
//   _ipl_o           active-low level presented to the CPU
//   ack_o            one-cycle strobe on acknowledge detection
//   ack_level_o      level acknowledged by the CPU, held
//   nmi_pending_o    latched level-7 request not yet acknowledged
//   spurious_o       one-cycle strobe: acknowledged level != presented level
module ipl_encoder
  import ipl_pkg::*;
#(
  parameter int FILTER = 2,
  parameter int REARM  = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  irq_level_i,
  input  logic        int7_i,
  input  logic [22:0] cpu_address_i,
  input  logic        _cpu_as_i,
  input  logic        cpu_rd_i,
  output logic [2:0]  _ipl_o,
  output logic        ack_o,
  output logic [2:0]  ack_level_o,
  output logic        nmi_pending_o,
  output logic        spurious_o
);

  localparam logic [2:0] REARM_VAL = 3'(REARM);

  state_e     state_q, state_d;
  logic       int7_q;
  logic       nmi_q, nmi_d;
  logic [2:0] rearm_q, rearm_d;
  logic       ack_q, ack_d;
  logic       spur_q, spur_d;
  logic [2:0] ack_level_q, ack_level_d;

  logic       int7_rise_s;
  logic       ackcyc_s;
  logic [2:0] req_s;
  logic [2:0] cand_s;
  logic       freeze_s;

  assign int7_rise_s = int7_i & ~int7_q;
  assign ackcyc_s    = ((cpu_address_i & ACK_ADDR_MASK) == ACK_ADDR_MASK)
                       & ~_cpu_as_i & cpu_rd_i;
  assign freeze_s    = (state_q != IDLE);

  // Level 7 is masked while a re-arm is in progress so the CPU sees _ipl
  // leave 7 and can take the next edge.
  always_comb begin
    if (nmi_q && (rearm_q == 3'd0)) begin
      req_s = LVL_NMI;
    end else begin
      req_s = sat6(irq_level_i);
    end
  end

  ipl_filter #(.FILTER(FILTER)) u_filter (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .freeze_i (freeze_s),
    .req_i    (req_s),
    .cand_o   (cand_s),
    ._ipl_o   (_ipl_o)
  );

  // Acknowledge FSM, level-7 latch and re-arm counter next state.
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    spur_d      = 1'b0;
    ack_level_d = ack_level_q;
    nmi_d       = nmi_q;
    rearm_d     = rearm_q;
    case (state_q)
      IDLE: begin
        if (ackcyc_s) begin
          state_d     = ACK;
          ack_d       = 1'b1;
          ack_level_d = cpu_address_i[2:0];
          spur_d      = (cpu_address_i[2:0] != cand_s) | (cand_s == 3'd0);
        end else begin
          state_d = IDLE;
        end
        // The re-arm window counts only once the lower level is actually on
        // _ipl; counting through the filter latency could leave _ipl at 7.
        if ((rearm_q != 3'd0) && (cand_s != LVL_NMI)) begin
          rearm_d = rearm_q - 3'd1;
        end else begin
          rearm_d = rearm_q;
        end
      end
      ACK: begin
        state_d = WAIT_AS;
        if (ack_level_q == LVL_NMI) begin
          nmi_d   = 1'b0;
          rearm_d = REARM_VAL;
        end else begin
          nmi_d   = nmi_q;
        end
      end
      WAIT_AS: begin
        if (_cpu_as_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_AS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new edge wins over an acknowledge clear in the same cycle.
    if (int7_rise_s) begin
      nmi_d = 1'b1;
    end else begin
      nmi_d = nmi_d;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      int7_q      <= 1'b0;
      nmi_q       <= 1'b0;
      rearm_q     <= 3'd0;
      ack_q       <= 1'b0;
      spur_q      <= 1'b0;
      ack_level_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      int7_q      <= int7_i;
      nmi_q       <= nmi_d;
      rearm_q     <= rearm_d;
      ack_q       <= ack_d;
      spur_q      <= spur_d;
      ack_level_q <= ack_level_d;
    end
  end

  assign ack_o         = ack_q;
  assign ack_level_o   = ack_level_q;
  assign nmi_pending_o = nmi_q;
  assign spurious_o    = spur_q;

endmodule
